hrm_control_unit_mc: RTL and testbench

- Next-generation HRM CPU control FSM, parametrised for multiple INBOX/OUTBOX channels.
- Adds a built-in WAIT timer (no external timer handshake), an I/O stall watchdog with fault reporting, and a channel-select output.
- Sits between IR/flags and the datapath, like the current control unit.
- Drives the same datapath strobes plus ch_sel, fault and fault_code.

---
 rtl/hrm_control_unit_mc_if.sv | 41 ++++
 rtl/hrm_control_unit_mc.sv | 229 ++++++++++++++++++++++
 tb/tb_hrm_control_unit_mc.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hrm_control_unit_mc_if.sv
// Control-unit <-> IR/flags/datapath bundle for hrm_control_unit_mc.
// Optional breakpoint inputs exist only when HRM_CU_BREAKPOINT_EN is defined.
interface hrm_control_unit_mc_if #(
  parameter int unsigned N_IN_CH  = 2,
  parameter int unsigned N_OUT_CH = 2
);
  logic [7:0]          INSTR;
  logic [N_IN_CH-1:0]  inEmpty;
  logic [N_OUT_CH-1:0] outFull;
  logic                debug;
  logic                nxtInstr;
`ifdef HRM_CU_BREAKPOINT_EN
  logic [7:0]          PC;
  logic [7:0]          bp_addr;
  logic                bp_en;
`endif
  logic                wIR, wR, srcA, wM, wAR, wPC, rIn, wO, ijump, branch, rst, halt;
  logic [1:0]          muxR;
  logic [2:0]          aluCtl;
  logic [2:0]          ch_sel;
  logic                fault;
  logic [1:0]          fault_code;

  modport master (
    input  INSTR, inEmpty, outFull, debug, nxtInstr,
`ifdef HRM_CU_BREAKPOINT_EN
    input  PC, bp_addr, bp_en,
`endif
    output wIR, wR, srcA, wM, wAR, wPC, rIn, wO, ijump, branch, rst, halt,
    output muxR, aluCtl, ch_sel, fault, fault_code
  );

  modport slave (
    output INSTR, inEmpty, outFull, debug, nxtInstr,
`ifdef HRM_CU_BREAKPOINT_EN
    output PC, bp_addr, bp_en,
`endif
    input  wIR, wR, srcA, wM, wAR, wPC, rIn, wO, ijump, branch, rst, halt,
    input  muxR, aluCtl, ch_sel, fault, fault_code
  );
endinterface

// File: rtl/hrm_control_unit_mc.sv
// Multi-channel HRM control FSM with WAIT timer, I/O stall watchdog and fault reporting.
// Define HRM_CU_BREAKPOINT_EN to add PC/bp_addr/bp_en breakpoint support.
module hrm_control_unit_mc #(
  parameter int unsigned N_IN_CH    = 2,
  parameter int unsigned N_OUT_CH   = 2,
  parameter int unsigned IO_TIMEOUT = 1024,
  parameter int unsigned WAIT_UNIT  = 16,
  parameter int unsigned CNT_W      = 16
) (
  input logic                  clk,
  input logic                  i_rst,
  hrm_control_unit_mc_if.master bus
);

  typedef enum logic [4:0] {
    S_RESET, S_INC_PC, S_FETCH_I, S_WAIT_KEY, S_LOAD_IR, S_DECODE, S_INCPC2,
    S_FETCH_O, S_LOAD_AR, S_READMEM, S_READMEM2, S_LOAD_AR2, S_INBOX, S_OUTBOX,
    S_COPYFROM, S_COPYTO, S_ADD, S_SUB, S_BUMPP, S_BUMPN, S_SET, S_JUMP,
    S_JUMPZ, S_JUMPN, S_HALT, S_FAULT, S_WAIT_TMR
  } state_t;

  typedef enum logic [3:0] {
    OP_INBOX, OP_OUTBOX, OP_COPYFROM, OP_COPYTO, OP_ADD, OP_SUB, OP_BUMPP,
    OP_BUMPN, OP_JUMP, OP_JUMPZ, OP_JUMPN, OP_NOP0, OP_NOP1, OP_WAIT, OP_SET,
    OP_HALT
  } opcode_t;

  typedef struct packed {
    logic       wIR, wR, srcA, wM, wAR, wPC, rIn, wO, ijump, branch, rst, halt;
    logic [1:0] muxR;
    logic [2:0] aluCtl;
  } strobes_t;

  function automatic strobes_t strobes_of(input state_t s);
    strobes_t o;
    o = '0;
    case (s)
      S_RESET:    o.rst = 1'b1;
      S_INC_PC,
      S_INCPC2:   o.wPC = 1'b1;
      S_LOAD_IR:  o.wIR = 1'b1;
      S_INBOX:    begin o.rIn = 1'b1; o.wR = 1'b1; end
      S_OUTBOX:   o.wO = 1'b1;
      S_COPYFROM: begin o.muxR = 2'b01; o.wR = 1'b1; end
      S_COPYTO:   o.wM = 1'b1;
      S_ADD:      begin o.muxR = 2'b11; o.wR = 1'b1; o.aluCtl = 3'b000; end
      S_SUB:      begin o.muxR = 2'b11; o.wR = 1'b1; o.aluCtl = 3'b001; end
      S_BUMPP:    begin o.muxR = 2'b11; o.wR = 1'b1; o.aluCtl = 3'b010; end
      S_BUMPN:    begin o.muxR = 2'b11; o.wR = 1'b1; o.aluCtl = 3'b011; end
      S_SET:      begin o.muxR = 2'b10; o.wR = 1'b1; end
      S_LOAD_AR:  o.wAR = 1'b1;
      S_LOAD_AR2: begin o.wAR = 1'b1; o.srcA = 1'b1; end
      S_JUMP:     begin o.branch = 1'b1; o.ijump = 1'b1; o.wPC = 1'b1; end
      S_JUMPZ:    begin o.branch = 1'b1; o.wPC = 1'b1; o.aluCtl = 3'b000; end
      S_JUMPN:    begin o.branch = 1'b1; o.wPC = 1'b1; o.aluCtl = 3'b100; end
      S_HALT,
      S_FAULT:    o.halt = 1'b1;
      default:    o = '0;
    endcase
    return o;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [2:0]       ch_q;
  logic             fault_q;
  logic [1:0]       code_q, code_d;
  strobes_t         out_q, out_d;

  opcode_t    op;
  logic       ind;
  logic [2:0] ch;
  logic [7:0] in_pad, out_pad;
  logic       blocked;
  logic       bp_hit;

  assign op  = opcode_t'(bus.INSTR[7:4]);
  assign ind = bus.INSTR[3];
  assign ch  = bus.INSTR[2:0];

  // Unused channel slots read as empty/full so they can never look ready.
  always_comb begin
    in_pad  = '1;
    out_pad = '1;
    in_pad[N_IN_CH-1:0]   = bus.inEmpty;
    out_pad[N_OUT_CH-1:0] = bus.outFull;
  end

`ifdef HRM_CU_BREAKPOINT_EN
  logic       bp_hold_q;
  logic [7:0] bp_pc_q;
  assign bp_hit = bus.bp_en && (bus.PC == bus.bp_addr) &&
                  !(bp_hold_q && (bus.PC == bp_pc_q));
`else
  assign bp_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    wait_d  = wait_q;
    code_d  = 2'd0;
    blocked = 1'b0;
    case (state_q)
      S_RESET:    state_d = S_FETCH_I;
      S_INC_PC:   state_d = S_FETCH_I;
      S_FETCH_I:  state_d = (bus.debug || bp_hit) ? S_WAIT_KEY : S_LOAD_IR;
      S_WAIT_KEY: if (bus.nxtInstr) state_d = S_LOAD_IR;
      S_LOAD_IR:  begin state_d = S_DECODE; stall_d = '0; end
      S_DECODE: begin
        case (op)
          OP_INBOX:
            if (32'(ch) >= N_IN_CH) begin state_d = S_FAULT; code_d = 2'd2; end
            else if (!in_pad[ch]) state_d = S_INBOX;
            else blocked = 1'b1;
          OP_OUTBOX:
            if (32'(ch) >= N_OUT_CH) begin state_d = S_FAULT; code_d = 2'd2; end
            else if (!out_pad[ch]) state_d = S_OUTBOX;
            else blocked = 1'b1;
          OP_HALT:          state_d = S_HALT;
          OP_NOP0, OP_NOP1: state_d = S_INC_PC;
          OP_WAIT: begin
            state_d = S_WAIT_TMR;
            wait_d  = CNT_W'((32'(ch) + 32'd1) * WAIT_UNIT - 32'd1);
          end
          default:          state_d = S_INCPC2;
        endcase
        // A flag that clears on the final allowed cycle is already handled above.
        if (blocked) begin
          if (IO_TIMEOUT != 0 && stall_q == CNT_W'(IO_TIMEOUT - 1)) begin
            state_d = S_FAULT;
            code_d  = 2'd1;
          end else begin
            stall_d = stall_q + CNT_W'(1);
          end
        end
      end
      S_INCPC2: state_d = S_FETCH_O;
      S_FETCH_O:
        case (op)
          OP_JUMP:  state_d = S_JUMP;
          OP_JUMPZ: state_d = S_JUMPZ;
          OP_JUMPN: state_d = S_JUMPN;
          OP_SET:   state_d = S_SET;
          default:  state_d = S_LOAD_AR;
        endcase
      S_LOAD_AR:
        if (ind)                 state_d = S_READMEM2;
        else if (op == OP_COPYTO) state_d = S_COPYTO;
        else                     state_d = S_READMEM;
      S_READMEM2: state_d = S_LOAD_AR2;
      S_LOAD_AR2: state_d = (op == OP_COPYTO) ? S_COPYTO : S_READMEM;
      S_READMEM:
        case (op)
          OP_COPYFROM: state_d = S_COPYFROM;
          OP_ADD:      state_d = S_ADD;
          OP_SUB:      state_d = S_SUB;
          OP_BUMPP:    state_d = S_BUMPP;
          OP_BUMPN:    state_d = S_BUMPN;
          default:     begin state_d = S_FAULT; code_d = 2'd3; end
        endcase
      S_BUMPP, S_BUMPN: state_d = S_COPYTO;
      S_COPYTO, S_COPYFROM, S_ADD, S_SUB, S_SET, S_INBOX, S_OUTBOX:
        state_d = S_INC_PC;
      S_JUMP, S_JUMPZ, S_JUMPN: state_d = S_FETCH_I;
      S_HALT:   state_d = S_HALT;
      S_FAULT:  state_d = S_FAULT;
      S_WAIT_TMR:
        if (wait_q == '0) state_d = S_INC_PC;
        else              wait_d  = wait_q - CNT_W'(1);
      default: begin state_d = S_FAULT; code_d = 2'd3; end
    endcase
    out_d = strobes_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (!i_rst) begin
      state_q <= S_RESET;
      stall_q <= '0;
      wait_q  <= '0;
      ch_q    <= '0;
      fault_q <= 1'b0;
      code_q  <= '0;
      out_q   <= strobes_of(S_RESET);
`ifdef HRM_CU_BREAKPOINT_EN
      bp_hold_q <= 1'b0;
      bp_pc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      wait_q  <= wait_d;
      out_q   <= out_d;
      if (state_q == S_DECODE) ch_q <= ch;
      if (state_d == S_FAULT && !fault_q) begin
        fault_q <= 1'b1;
        code_q  <= code_d;
      end
`ifdef HRM_CU_BREAKPOINT_EN
      if (state_q == S_FETCH_I && bp_hit && !bus.debug) begin
        bp_hold_q <= 1'b1;
        bp_pc_q   <= bus.PC;
      end else if (bus.PC != bp_pc_q) begin
        bp_hold_q <= 1'b0;
      end
`endif
    end
  end

  assign bus.wIR        = out_q.wIR;
  assign bus.wR         = out_q.wR;
  assign bus.srcA       = out_q.srcA;
  assign bus.wM         = out_q.wM;
  assign bus.wAR        = out_q.wAR;
  assign bus.wPC        = out_q.wPC;
  assign bus.rIn        = out_q.rIn;
  assign bus.wO         = out_q.wO;
  assign bus.ijump      = out_q.ijump;
  assign bus.branch     = out_q.branch;
  assign bus.rst        = out_q.rst;
  assign bus.halt       = out_q.halt;
  assign bus.muxR       = out_q.muxR;
  assign bus.aluCtl     = out_q.aluCtl;
  assign bus.ch_sel     = ch_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;

endmodule

// File: tb/tb_hrm_control_unit_mc.sv
// Directed bench for hrm_control_unit_mc (IO_TIMEOUT=8, WAIT_UNIT=4, 2+2 channels).
module tb_hrm_control_unit_mc;
  logic clk = 1'b0;
  logic i_rst;
  always #5 clk = ~clk;

  hrm_control_unit_mc_if #(.N_IN_CH(2), .N_OUT_CH(2)) bus();

  hrm_control_unit_mc #(
    .N_IN_CH(2), .N_OUT_CH(2), .IO_TIMEOUT(8), .WAIT_UNIT(4), .CNT_W(16)
  ) dut (
    .clk(clk),
    .i_rst(i_rst),
    .bus(bus)
  );

  // Packed view: {wIR,wR,srcA,wM,wAR,wPC,rIn,wO,ijump,branch,rst,halt,muxR,aluCtl}
  localparam logic [16:0] E_NONE  = 17'h00000;
  localparam logic [16:0] E_WIR   = 17'h10000;
  localparam logic [16:0] E_WR    = 17'h08000;
  localparam logic [16:0] E_SRCA  = 17'h04000;
  localparam logic [16:0] E_WM    = 17'h02000;
  localparam logic [16:0] E_WAR   = 17'h01000;
  localparam logic [16:0] E_WPC   = 17'h00800;
  localparam logic [16:0] E_RIN   = 17'h00400;
  localparam logic [16:0] E_WO    = 17'h00200;
  localparam logic [16:0] E_IJUMP = 17'h00100;
  localparam logic [16:0] E_BR    = 17'h00080;
  localparam logic [16:0] E_RST   = 17'h00040;
  localparam logic [16:0] E_HALT  = 17'h00020;
  localparam logic [16:0] E_MUX11 = 17'h00018;

  int errors = 0;
  int checks = 0;

  function automatic logic [16:0] strb();
    return {bus.wIR, bus.wR, bus.srcA, bus.wM, bus.wAR, bus.wPC, bus.rIn, bus.wO,
            bus.ijump, bus.branch, bus.rst, bus.halt, bus.muxR, bus.aluCtl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [7:0] instr);
    bus.INSTR = instr;
    i_rst = 1'b0;
    tick();
    tick();
    i_rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [16:0] exp [5];
    bus.INSTR = 8'hB0;
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (strb() !== E_RST || bus.fault !== 1'b0 || bus.fault_code !== 2'd0 || bus.ch_sel !== 3'd0) begin
        errors++;
        $display("FAIL reset_state cyc%0d: strb=%h fault=%b code=%0d ch=%0d, expected strb=%h fault=0 code=0 ch=0",
                 i, strb(), bus.fault, bus.fault_code, bus.ch_sel, E_RST);
      end
    end
    i_rst = 1'b1;
    exp = '{E_NONE, E_WIR, E_NONE, E_WPC, E_NONE};
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (strb() !== exp[i] || bus.fault !== 1'b0) begin
        errors++;
        $display("FAIL reset_exit step%0d: strb=%h fault=%b, expected strb=%h fault=0",
                 i, strb(), bus.fault, exp[i]);
      end
    end
  endtask

  task automatic test_inbox_stall();
    logic [16:0] exp [3];
    bus.inEmpty = 2'b10;
    apply_reset(8'h01);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (strb() !== E_NONE) begin
        errors++;
        $display("FAIL inbox_stall cyc%0d: strb=%h, expected %h", i, strb(), E_NONE);
      end
    end
    bus.inEmpty = 2'b00;
    exp = '{E_RIN | E_WR, E_WPC, E_NONE};
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (strb() !== exp[i] || bus.ch_sel !== 3'd1 || bus.fault !== 1'b0) begin
        errors++;
        $display("FAIL inbox_go step%0d: strb=%h ch=%0d fault=%b, expected strb=%h ch=1 fault=0",
                 i, strb(), bus.ch_sel, bus.fault, exp[i]);
      end
    end
  endtask

  task automatic test_io_timeout();
    bus.outFull = 2'b01;
    apply_reset(8'h10);
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (strb() !== E_NONE || bus.fault !== 1'b0) begin
        errors++;
        $display("FAIL timeout_stall cyc%0d: strb=%h fault=%b, expected strb=%h fault=0",
                 i, strb(), bus.fault, E_NONE);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (strb() !== E_HALT || bus.fault !== 1'b1 || bus.fault_code !== 2'd1) begin
        errors++;
        $display("FAIL timeout_fault step%0d: strb=%h fault=%b code=%0d, expected strb=%h fault=1 code=1",
                 i, strb(), bus.fault, bus.fault_code, E_HALT);
      end
    end
    i_rst = 1'b0;
    tick();
    checks++;
    if (strb() !== E_RST || bus.fault !== 1'b0 || bus.fault_code !== 2'd0) begin
      errors++;
      $display("FAIL fault_reset: strb=%h fault=%b code=%0d, expected strb=%h fault=0 code=0",
               strb(), bus.fault, bus.fault_code, E_RST);
    end
    bus.outFull = 2'b00;
  endtask

  task automatic test_timeout_boundary();
    bus.outFull = 2'b01;
    apply_reset(8'h10);
    tick(); tick();
    for (int i = 0; i < 8; i++) tick();
    bus.outFull = 2'b00;
    tick();
    checks++;
    if (strb() !== E_WO || bus.fault !== 1'b0) begin
      errors++;
      $display("FAIL timeout_boundary: strb=%h fault=%b, expected strb=%h fault=0",
               strb(), bus.fault, E_WO);
    end
  endtask

  task automatic test_bad_channel();
    bus.inEmpty = 2'b00;
    apply_reset(8'h03);
    tick(); tick(); tick();
    checks++;
    if (strb() !== E_NONE) begin
      errors++;
      $display("FAIL badch_decode: strb=%h, expected %h", strb(), E_NONE);
    end
    tick();
    checks++;
    if (strb() !== E_HALT || bus.fault !== 1'b1 || bus.fault_code !== 2'd2) begin
      errors++;
      $display("FAIL badch_fault: strb=%h fault=%b code=%0d, expected strb=%h fault=1 code=2",
               strb(), bus.fault, bus.fault_code, E_HALT);
    end
  endtask

  task automatic test_wait();
    apply_reset(8'hD2);
    tick(); tick(); tick();
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (strb() !== E_NONE) begin
        errors++;
        $display("FAIL wait_dwell cyc%0d: strb=%h, expected %h", i, strb(), E_NONE);
      end
    end
    tick();
    checks++;
    if (strb() !== E_WPC || bus.ch_sel !== 3'd2) begin
      errors++;
      $display("FAIL wait_end: strb=%h ch=%0d, expected strb=%h ch=2", strb(), bus.ch_sel, E_WPC);
    end
  endtask

  task automatic test_indirect_add();
    logic [16:0] exp [9];
    apply_reset(8'h48);
    tick(); tick(); tick();
    exp = '{E_WPC, E_NONE, E_WAR, E_NONE, E_WAR | E_SRCA, E_NONE, E_WR | E_MUX11, E_WPC, E_NONE};
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (strb() !== exp[i]) begin
        errors++;
        $display("FAIL indirect_add step%0d: strb=%h, expected %h", i, strb(), exp[i]);
      end
    end
  endtask

  task automatic test_jumps_bump();
    logic [16:0] ej [4];
    logic [16:0] eb [7];
    apply_reset(8'h80);
    tick(); tick(); tick();
    ej = '{E_WPC, E_NONE, E_BR | E_IJUMP | E_WPC, E_NONE};
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (strb() !== ej[i]) begin
        errors++;
        $display("FAIL jump step%0d: strb=%h, expected %h", i, strb(), ej[i]);
      end
    end
    apply_reset(8'hA0);
    tick(); tick(); tick(); tick(); tick();
    tick();
    checks++;
    if (strb() !== (E_BR | E_WPC | 17'h00004)) begin
      errors++;
      $display("FAIL jumpn: strb=%h, expected %h", strb(), E_BR | E_WPC | 17'h00004);
    end
    apply_reset(8'h70);
    tick(); tick(); tick();
    eb = '{E_WPC, E_NONE, E_WAR, E_NONE, E_WR | E_MUX11 | 17'h00003, E_WM, E_WPC};
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (strb() !== eb[i]) begin
        errors++;
        $display("FAIL bump_minus step%0d: strb=%h, expected %h", i, strb(), eb[i]);
      end
    end
  endtask

  task automatic test_debug_halt();
    bus.debug = 1'b1;
    bus.nxtInstr = 1'b0;
    apply_reset(8'hF0);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (strb() !== E_NONE) begin
        errors++;
        $display("FAIL wait_key cyc%0d: strb=%h, expected %h", i, strb(), E_NONE);
      end
    end
    bus.nxtInstr = 1'b1;
    tick();
    checks++;
    if (strb() !== E_WIR) begin
      errors++;
      $display("FAIL step_load: strb=%h, expected %h", strb(), E_WIR);
    end
    bus.nxtInstr = 1'b0;
    bus.debug = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (strb() !== E_HALT || bus.fault !== 1'b0) begin
        errors++;
        $display("FAIL halt step%0d: strb=%h fault=%b, expected strb=%h fault=0",
                 i, strb(), bus.fault, E_HALT);
      end
    end
  endtask

  initial begin
    i_rst        = 1'b0;
    bus.INSTR    = 8'h00;
    bus.inEmpty  = 2'b11;
    bus.outFull  = 2'b00;
    bus.debug    = 1'b0;
    bus.nxtInstr = 1'b0;
`ifdef HRM_CU_BREAKPOINT_EN
    bus.PC      = 8'h00;
    bus.bp_addr = 8'h00;
    bus.bp_en   = 1'b0;
`endif
    test_reset();
    test_inbox_stall();
    test_io_timeout();
    test_timeout_boundary();
    test_bad_channel();
    test_wait();
    test_indirect_add();
    test_jumps_bump();
    test_debug_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
